// File: rtl/adc_block_averager.sv
// adc_block_averager: decimating boxcar averager over 2^k signed samples.
// Each block produces its rounded mean, minimum and maximum.
`default_nettype none

module adc_block_averager #(
   parameter int DATA_WIDTH = 16,
   parameter int LOG2_MAX_N = 8
) (
   input  logic                  clk_in,
   input  logic                  rst_n_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  valid_in,
   input  logic [3:0]            log2_n_in,
   input  logic                  clear_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [DATA_WIDTH-1:0] min_out,
   output logic [DATA_WIDTH-1:0] max_out,
   output logic                  valid_out,
   output logic                  busy_out
);

   localparam int KW = $clog2(LOG2_MAX_N + 1);
   localparam int AW = DATA_WIDTH + LOG2_MAX_N;
   localparam int CW = LOG2_MAX_N + 1;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      ACCUM = 1'b1
   } state_t;

   state_t                        state;
   logic signed [AW-1:0]          acc;
   logic signed [DATA_WIDTH-1:0]  run_min;
   logic signed [DATA_WIDTH-1:0]  run_max;
   logic [CW-1:0]                 count;
   logic [KW-1:0]                 k_act;

   logic signed [DATA_WIDTH-1:0]  sample;
   logic signed [AW-1:0]          sample_ext;
   logic [KW-1:0]                 k_clamp;
   logic [KW-1:0]                 k_eff;
   logic signed [AW-1:0]          sum_next;
   logic signed [DATA_WIDTH-1:0]  min_next;
   logic signed [DATA_WIDTH-1:0]  max_next;
   logic                          blk_last;
   logic signed [AW:0]            bias;
   logic signed [AW:0]            biased;
   logic signed [AW:0]            shifted;
   logic signed [DATA_WIDTH-1:0]  mean;

   always_comb begin
      sample     = data_in;
      sample_ext = {{LOG2_MAX_N{data_in[DATA_WIDTH-1]}}, data_in};

      if (int'(log2_n_in) > LOG2_MAX_N) begin
         k_clamp = KW'(LOG2_MAX_N);
      end else begin
         k_clamp = KW'(log2_n_in);
      end

      // A sample taken in IDLE starts a block and must use the freshly clamped k.
      if (state == IDLE) begin
         k_eff    = k_clamp;
         sum_next = sample_ext;
         min_next = sample;
         max_next = sample;
         blk_last = (k_clamp == '0);
      end else begin
         k_eff    = k_act;
         sum_next = acc + sample_ext;
         min_next = (sample < run_min) ? sample : run_min;
         max_next = (sample > run_max) ? sample : run_max;
         blk_last = ((count + CW'(1)) == (CW'(1) << k_act));
      end

      // Round half toward +inf, then arithmetic shift (floor).
      if (k_eff == '0) begin
         bias = '0;
      end else begin
         bias = (AW+1)'(1) << (k_eff - KW'(1));
      end
      biased  = {sum_next[AW-1], sum_next} + bias;
      shifted = biased >>> k_eff;
      mean    = DATA_WIDTH'(shifted);
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state     <= IDLE;
         acc       <= '0;
         run_min   <= '0;
         run_max   <= '0;
         count     <= '0;
         k_act     <= '0;
         data_out  <= '0;
         min_out   <= '0;
         max_out   <= '0;
         valid_out <= 1'b0;
         busy_out  <= 1'b0;
      end else begin
         valid_out <= 1'b0;
         if (clear_in) begin
            state    <= IDLE;
            count    <= '0;
            busy_out <= 1'b0;
         end else if (valid_in) begin
            if (state == IDLE) begin
               k_act <= k_clamp;
            end
            if (blk_last) begin
               data_out  <= mean;
               min_out   <= min_next;
               max_out   <= max_next;
               valid_out <= 1'b1;
               state     <= IDLE;
               count     <= '0;
               busy_out  <= 1'b0;
            end else begin
               acc      <= sum_next;
               run_min  <= min_next;
               run_max  <= max_next;
               count    <= count + CW'(1);
               state    <= ACCUM;
               busy_out <= 1'b1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_adc_block_averager.sv
// Scoreboard bench for adc_block_averager: directed blocks plus randomised traffic.
`default_nettype none

module tb_adc_block_averager;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b0;
   logic [15:0] data_in = '0;
   logic        valid_in = 1'b0;
   logic [3:0]  log2_n_in = '0;
   logic        clear_in = 1'b0;
   logic [15:0] data_out;
   logic [15:0] min_out;
   logic [15:0] max_out;
   logic        valid_out;
   logic        busy_out;

   adc_block_averager #(.DATA_WIDTH(16), .LOG2_MAX_N(8)) dut (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .data_in   (data_in),
      .valid_in  (valid_in),
      .log2_n_in (log2_n_in),
      .clear_in  (clear_in),
      .data_out  (data_out),
      .min_out   (min_out),
      .max_out   (max_out),
      .valid_out (valid_out),
      .busy_out  (busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      logic [15:0] mean;
      logic [15:0] mn;
      logic [15:0] mx;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          exp_pulses = 0;
   int          obs_pulses = 0;

   // reference model state
   int          m_cnt = 0;
   int          m_k = 0;
   int          m_sum = 0;
   int          m_min = 0;
   int          m_max = 0;

   logic [15:0] prev_data = '0;
   logic [15:0] prev_min = '0;
   logic [15:0] prev_max = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int clamp_k(input logic [3:0] k);
      return (int'(k) > 8) ? 8 : int'(k);
   endfunction

   // Drive one cycle of inputs, let the DUT capture them, then advance the model.
   task automatic step(input logic v, input logic [15:0] d, input logic clr);
      int s;
      exp_t e;
      valid_in = v;
      data_in  = d;
      clear_in = clr;
      @(posedge clk_in);
      #1;
      s = int'($signed(d));
      if (clr) begin
         m_cnt = 0;
      end else if (v) begin
         if (m_cnt == 0) begin
            m_k   = clamp_k(log2_n_in);
            m_sum = s;
            m_min = s;
            m_max = s;
         end else begin
            m_sum += s;
            if (s < m_min) m_min = s;
            if (s > m_max) m_max = s;
         end
         m_cnt++;
         if (m_cnt == (1 << m_k)) begin
            e.mean = 16'((m_sum + ((m_k > 0) ? (1 << (m_k - 1)) : 0)) >>> m_k);
            e.mn   = 16'(m_min);
            e.mx   = 16'(m_max);
            sb.push_back(e);
            exp_pulses++;
            m_cnt = 0;
         end
      end
      chk("busy", {31'b0, busy_out}, {31'b0, (m_cnt != 0)});
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 1'b0);
   endtask

   // Output monitor: pops the scoreboard on every pulse and checks hold otherwise.
   always @(negedge clk_in) begin
      exp_t e;
      if (!rst_n_in) begin
         prev_data = '0;
         prev_min  = '0;
         prev_max  = '0;
      end else if (valid_out) begin
         obs_pulses++;
         if (sb.size() == 0) begin
            chk("spurious_valid", {31'b0, valid_out}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk("mean", {16'b0, data_out}, {16'b0, e.mean});
            chk("min",  {16'b0, min_out},  {16'b0, e.mn});
            chk("max",  {16'b0, max_out},  {16'b0, e.mx});
         end
         prev_data = data_out;
         prev_min  = min_out;
         prev_max  = max_out;
      end else begin
         chk("hold_data", {16'b0, data_out}, {16'b0, prev_data});
         chk("hold_min",  {16'b0, min_out},  {16'b0, prev_min});
         chk("hold_max",  {16'b0, max_out},  {16'b0, prev_max});
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      #12;
      chk("rst_data",  {16'b0, data_out}, 32'd0);
      chk("rst_min",   {16'b0, min_out},  32'd0);
      chk("rst_max",   {16'b0, max_out},  32'd0);
      chk("rst_valid", {31'b0, valid_out}, 32'd0);
      chk("rst_busy",  {31'b0, busy_out},  32'd0);
      @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      idle(2);

      // k=0 pass-through, back to back
      log2_n_in = 4'd0;
      step(1'b1, 16'd100, 1'b0);
      step(1'b1, 16'hFFFB, 1'b0);
      idle(3);

      // k=2: 1,2,3,4 -> 3
      log2_n_in = 4'd2;
      step(1'b1, 16'd1, 1'b0);
      step(1'b1, 16'd2, 1'b0);
      step(1'b1, 16'd3, 1'b0);
      chk("k2_no_early_pulse", {31'b0, valid_out}, 32'd0);
      step(1'b1, 16'd4, 1'b0);
      chk("k2_pulse", {31'b0, valid_out}, 32'd1);
      idle(3);

      // k=1: -1,-2 -> -1
      log2_n_in = 4'd1;
      step(1'b1, 16'hFFFF, 1'b0);
      step(1'b1, 16'hFFFE, 1'b0);
      idle(3);

      // k=8 extremes, no wrap
      log2_n_in = 4'd8;
      for (int i = 0; i < 256; i++) step(1'b1, 16'h7FFF, 1'b0);
      for (int i = 0; i < 256; i++) step(1'b1, 16'h8000, 1'b0);
      idle(3);
      chk("k8_neg_full", {16'b0, data_out}, 32'h8000);

      // k change mid-block is ignored until the next block
      log2_n_in = 4'd2;
      step(1'b1, 16'd10, 1'b0);
      step(1'b1, 16'd20, 1'b0);
      log2_n_in = 4'd0;
      step(1'b1, 16'd30, 1'b0);
      chk("kchg_no_pulse", {31'b0, valid_out}, 32'd0);
      step(1'b1, 16'd41, 1'b0);
      step(1'b1, 16'd7, 1'b0);
      step(1'b1, 16'hFFF0, 1'b0);
      idle(3);

      // log2_n_in=15 clamps to 8
      log2_n_in = 4'd15;
      for (int i = 0; i < 256; i++) step(1'b1, 16'($urandom), 1'b0);
      idle(3);

      // clear coincident with the 4th sample
      log2_n_in = 4'd2;
      step(1'b1, 16'd1, 1'b0);
      step(1'b1, 16'd2, 1'b0);
      step(1'b1, 16'd3, 1'b0);
      step(1'b1, 16'd4, 1'b1);
      idle(2);
      for (int i = 0; i < 4; i++) step(1'b1, 16'd8, 1'b0);
      idle(3);
      chk("after_clear", {16'b0, data_out}, 32'd8);

      // reset mid-block
      for (int i = 0; i < 3; i++) step(1'b1, 16'd5, 1'b0);
      valid_in = 1'b0;
      rst_n_in = 1'b0;
      #1;
      chk("mid_rst_data", {16'b0, data_out}, 32'd0);
      chk("mid_rst_min",  {16'b0, min_out},  32'd0);
      chk("mid_rst_max",  {16'b0, max_out},  32'd0);
      chk("mid_rst_busy", {31'b0, busy_out}, 32'd0);
      m_cnt = 0;
      @(posedge clk_in);
      #1 rst_n_in = 1'b1;
      idle(2);
      for (int i = 0; i < 4; i++) step(1'b1, 16'd9, 1'b0);
      idle(3);

      // random k, data, gaps and mid-block k changes
      for (int b = 0; b < 1500; b++) begin
         if ($urandom_range(0, 9) == 0) log2_n_in = 4'($urandom_range(0, 9));
         if ($urandom_range(0, 3) == 0) step(1'b0, 16'($urandom), 1'b0);
         else step(1'b1, 16'($urandom), 1'b0);
      end
      log2_n_in = 4'd0;
      for (int b = 0; b < 40; b++) step(1'b1, 16'($urandom), 1'b0);
      idle(4);

      chk("sb_drained", sb.size(), 32'd0);
      chk("pulse_count", obs_pulses, exp_pulses);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/adc_block_averager.md
# adc_block_averager

Decimating boxcar averager placed between an LTC2195 channel output and an AD9783 DAC input (or any other sample consumer). It accepts 16-bit signed ADC samples qualified by a strobe and sums 2^k consecutive samples, with k selectable at runtime. At the end of each block it emits the rounded mean together with the block minimum and maximum. It lowers the effective sample rate and noise before the servo/DAC path.

## Interface
Parameters:
- DATA_WIDTH, 16: sample width, two's complement.
- LOG2_MAX_N, 8: largest supported log2 block length. Accumulator width is DATA_WIDTH+LOG2_MAX_N.

Ports:
- clk_in, input, 1: system clock (100 MHz). Single clock domain.
- rst_n_in, input, 1: reset, asynchronous assert, active-low. One clock; reset is asynchronous and active-low.
- data_in, input, DATA_WIDTH: signed ADC sample.
- valid_in, input, 1: one-cycle strobe marking a new data_in. May be asserted every cycle.
- log2_n_in, input, 4: block length exponent k. Values above LOG2_MAX_N are clamped to LOG2_MAX_N.
- clear_in, input, 1: synchronous flush of the partial block.
- data_out, output, DATA_WIDTH: signed rounded mean of the last completed block.
- min_out, output, DATA_WIDTH: signed minimum of the last completed block.
- max_out, output, DATA_WIDTH: signed maximum of the last completed block.
- valid_out, output, 1: one-cycle pulse when data_out, min_out and max_out update.
- busy_out, output, 1: high while a partial block is held (sample count not 0).

## Operation
- State: IDLE (count = 0) and ACCUM (0 < count < 2^k).
- Latching k:
  - The clamped k is latched as k_act on the valid_in that starts a block, i.e. any valid_in accepted while in IDLE.
  - Changes to log2_n_in during ACCUM are ignored until the next block starts.
- Block-start sample:
  - acc ← sign-extended data_in; run_min ← data_in; run_max ← data_in; count ← 1.
  - If k_act = 0, the block completes on this same sample.
- ACCUM sample:
  - acc ← acc + data_in.
  - run_min/run_max update using signed compare.
  - count ← count + 1.
- Block completion, on the sample where count+1 = 2^k_act:
  - data_out ← (acc_final + (k_act>0 ? 2^(k_act−1) : 0)) >>> k_act, i.e. round half toward +∞, arithmetic shift.
  - min_out/max_out ← final running values.
  - valid_out pulses.
  - Return to IDLE.
- No overflow is possible. |sum| ≤ 2^LOG2_MAX_N·2^(DATA_WIDTH−1) fits in the accumulator, and the rounded mean of in-range samples stays within [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1]. No saturation logic is required.
- clear_in:
  - Forces IDLE, count ← 0, and discards acc/run_min/run_max.
  - Outputs keep their last values and valid_out is not pulsed.
  - If clear_in and valid_in are high in the same cycle, clear wins and the sample is discarded.
- Output stability: data_out, min_out and max_out change only in the cycle valid_out is high; otherwise they are held.

## Timing
- Reset values: data_out = 0, min_out = 0, max_out = 0, valid_out = 0, busy_out = 0, count = 0, acc = 0, k_act = 0, state IDLE.
- Reset asserted mid-block: immediate return to reset values, and the partial block is lost. After deassertion the first valid_in starts a new block.
- Latency:
  - valid_out is high in the cycle after the clock edge that captured the final valid_in of a block.
  - Latency is 1 cycle for every k.
- Throughput: one sample per cycle. Back-to-back blocks have no dead cycle; the sample after a completing one starts the next block in the same cycle that valid_out is high.
- valid_out is never high two cycles in a row unless k_act = 0 and valid_in is continuous.
- busy_out is registered: high from the cycle after the block-start sample until the cycle after completion or clear. It is low throughout when k_act = 0.

## Test plan
- k=0, valid_in with 100 then −5 in consecutive cycles → data_out = 100 then −5, each with a one-cycle valid_out pulse one cycle after input; min_out = max_out = sample.
- k=2, samples 1, 2, 3, 4 → after the 4th: data_out = 3 ((10+2)>>>2), min_out = 1, max_out = 4, single valid_out pulse; none after samples 1–3.
- k=1, samples −1, −2 → data_out = −1 ((−3+1)>>>1). k=8 with 256×0x7FFF → 0x7FFF; 256×0x8000 → 0x8000, no wrap.
- k=2 block with 2 samples in, set log2_n_in = 0 → block still needs 2 more samples (output 2-sample-later pulse); the next samples pass through at k=0. log2_n_in = 15 behaves as k=8.
- k=2, 3 samples then clear_in coincident with a 4th valid_in → no valid_out; the next samples 8, 8, 8, 8 → data_out = 8. Repeat with rst_n_in low after 3 samples → all outputs 0 immediately.
- Random signed samples, random k, random gaps in valid_in → each data_out/min_out/max_out matches the reference model rounding formula; valid_out count = total samples / 2^k.
